// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a two-flop input synchronizer and a one-entry holding register.
// Define UART_RX_MAJORITY_EN to take every sample as a 2-of-3 vote around the bit centre.
`timescale 1ns / 1ps

module uart_rx #(
  parameter int unsigned CLOCK_HZ     = 50_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       end_flag,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);

`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned Lag = 1;
`else
  localparam int unsigned Lag = 0;
`endif

  // Decisions land Lag clocks after the nominal target; reloading the counter with Lag
  // keeps the bit period at exactly CLKS_PER_BIT.
  localparam logic [CntW-1:0] StartTgt  = CntW'(HALF_BIT - 1 + Lag);
  localparam logic [CntW-1:0] BitTgt    = CntW'(CLKS_PER_BIT - 1 + Lag);
  localparam logic [CntW-1:0] CntReload = CntW'(Lag);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state;
  logic            rx_meta;
  logic            rx_s;
  logic [CntW-1:0] clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  // hist holds rx_s at target-1 and target; rx_s itself is target+1.
  assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= 8'h00;
      end_flag  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      if (rd && end_flag) begin
        end_flag <= 1'b0;
        overrun  <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (!rx_s) begin
            state   <= StStart;
            clk_cnt <= '0;
          end
        end

        StStart: begin
          if (clk_cnt == StartTgt) begin
            if (!sample) begin
              state   <= StData;
              clk_cnt <= CntReload;
              bit_idx <= '0;
            end else begin
              state   <= StIdle;
              clk_cnt <= '0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        StData: begin
          if (clk_cnt == BitTgt) begin
            shift[bit_idx] <= sample;
            clk_cnt        <= CntReload;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= StStop;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        StStop: begin
          if (clk_cnt == BitTgt) begin
            clk_cnt <= '0;
            if (sample) begin
              // Load overrides the rd clear above; a coinciding rd still drops overrun.
              data     <= shift;
              end_flag <= 1'b1;
              overrun  <= rd ? 1'b0 : (overrun | end_flag);
              state    <= StIdle;
            end else begin
              frame_err <= 1'b1;
              state     <= StBreak;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        StBreak: begin
          if (rx_s) begin
            state <= StIdle;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Asynchronous 8N1 UART receiver for the jacaranda-8 `computer` top.
- Sits directly downstream of the board/bench `rx` pin and upstream of the CPU's memory-mapped UART port.
- Synchronizes the serial line, validates the start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit.
- Holds each good byte in a one-entry register, flagged by `end_flag` until the CPU acknowledges it.

## Interface
- `CLOCK_HZ`, 50_000_000: system clock frequency.
- `BAUD_RATE`, 115200: line rate.
- `CLKS_PER_BIT`, CLOCK_HZ/BAUD_RATE (integer division, 434): clocks per bit; must be ≥ 8.
- `HALF_BIT`, CLKS_PER_BIT/2 (217): clocks from start-bit edge to start-bit centre.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `rd`  in  1  one-cycle read acknowledge from the CPU; clears `end_flag` and `overrun`.
- `data`  out  8  last received byte.
- `end_flag`  out  1  level; high while `data` holds an unread byte.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `overrun`  out  1  sticky; an unread byte was overwritten.

## Operation
- **Reset values.**
  - `data`=8'h00, `end_flag`=0, `frame_err`=0, `overrun`=0.
  - Both synchronizer flops = 1.
  - State=IDLE, counters=0.
- **Synchronizer.** Two-flop synchronizer on `rx` produces `rx_s`. All decisions use `rx_s` only.
- **State machine.**
  - IDLE: `rx_s`==0 → START, `clk_cnt`=0.
  - START: on `clk_cnt`==HALF_BIT-1, sample the line.
    - Sample 0 → DATA, `clk_cnt`=0, `bit_idx`=0.
    - Sample 1 → IDLE (glitch rejected, nothing reported).
  - DATA: on `clk_cnt`==CLKS_PER_BIT-1, sample into `shift[bit_idx]` and reset `clk_cnt`.
    - `bit_idx` 0..7, wraps to 0.
    - After bit 7 → STOP.
  - STOP: on `clk_cnt`==CLKS_PER_BIT-1, sample the stop bit.
    - Sample 1 → load `data`=`shift`, set `end_flag`, → IDLE.
    - Sample 0 → pulse `frame_err`, leave `data` and `end_flag` untouched, → BREAK.
  - BREAK: wait for `rx_s`==1, then → IDLE. A held-low line produces exactly one `frame_err`.
- **Handshake.**
  - `rd` with `end_flag`=1 clears `end_flag` and `overrun` on the next edge.
  - `rd` with `end_flag`=0 has no effect.
- **Simultaneous load and `rd`.**
  - The load wins: `end_flag` stays 1 and `data` takes the new byte.
  - `overrun` is cleared, not set.
- **Overrun.** A load while `end_flag`=1 and `rd`=0 overwrites `data` and sets `overrun`=1, which stays set until `rd`.
- **Reset mid-frame.** The partial byte is discarded. After release, the receiver waits in IDLE, and a line still low starts a new frame.

## Timing
- Sampling instants:
  - Stop bit is sampled at the centre of bit 9.
  - Samples fall at HALF_BIT + k·CLKS_PER_BIT clocks after START entry, k=0..9.
- Latency:
  - `end_flag` rises HALF_BIT + 9·CLKS_PER_BIT + 3 clocks (±1) after the `rx` falling edge.
  - The 3 clocks are 2 synchronizer cycles plus 1 IDLE decision cycle.
- Back-to-back frames: the receiver re-enters IDLE at mid-stop-bit, so a start bit immediately following the stop bit is caught.
- Baud tolerance: ±2% cumulative clock/baud mismatch must decode correctly.
- `frame_err` and load happen in the same cycle position, the STOP sample cycle + 1.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Every sample (start, data, stop) is the 2-of-3 majority of `rx_s` at counter values target-1, target, target+1.
  - Decision is made at target+1, which adds 1 clock to end_flag latency.
  - A single-cycle glitch at mid-bit is rejected.
- Undefined: a single sample at the target count. Latency is exactly as stated in Timing.

## Test plan
- **Basic byte.** Idle 2 bit times, then start + bits 0,1,0,1,0,1,0,1 + stop at 115200 baud. Required:
  - `data`=8'hAA and `end_flag`=1 within HALF_BIT+9·434+3±1 clocks of the start edge.
  - `frame_err`=0 and `overrun`=0.
- **Glitch rejection.** 100 ns low pulse on idle `rx` → state returns to IDLE, `end_flag` stays 0, no `frame_err`.
- **Framing error.** Send 8'h55 with stop bit low, then hold low 3 bit times, then release. Required:
  - Exactly one `frame_err` pulse.
  - `end_flag`=0, `data` unchanged.
  - Next valid 8'h3C is received.
- **Overrun.** Send 8'h11 then 8'h22 back-to-back with no `rd`. Required:
  - `data`=8'h22, `end_flag`=1, `overrun`=1.
  - One `rd` clears both flags next cycle.
- **Simultaneous `rd` and load.** Pulse `rd` on the load cycle of 8'h7E. Required:
  - `end_flag`=1, `data`=8'h7E, `overrun`=0.
- **Async reset mid-frame.** Assert `rst_n`=0 during bit 4 of 8'hF0. Required:
  - All outputs at reset values immediately.
  - After release and a full idle bit time, 8'h0F is received correctly.
